tag_input_pio: RTL and testbench

//  Avalon-MM slave input port: samples WIDTH external inputs (keys/switches), synchronises
//  and debounces each bit, and captures edges into sticky bits.
//  A maskable level interrupt is raised to the HPS/processor.

---
 rtl/tag_pio_pkg.sv | 15 +
 rtl/tag_pio_debounce.sv | 56 +++++
 rtl/tag_input_pio.sv | 94 +++++++++
 tb/tb_tag_input_pio.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tag_pio_pkg.sv
// Shared constants for the input PIO: register addresses and edge-capture modes.
package tag_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_FALL = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/tag_pio_debounce.sv
// One input bit: 2-flop synchroniser followed by a stability counter.
// The debounced output only follows the synchronised value after it has
// differed for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts.
module tag_pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_BIT        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic deb
);

  logic s1, s2;

  // Synchroniser; reset to the idle level so leaving reset creates no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= IDLE_BIT;
      s2 <= IDLE_BIT;
    end else begin
      s1 <= in_bit;
      s2 <= s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: debounced value is just the synchronised value, registered.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) deb <= IDLE_BIT;
        else       deb <= s2;
      end
    end else begin : g_cnt
      localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt;

      // Count cycles of disagreement; accept the new level on the last one.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt <= '0;
          deb <= IDLE_BIT;
        end else if (s2 == deb) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tag_input_pio.sv
// Avalon-MM input PIO: debounced inputs, sticky edge capture, maskable
// level interrupt and a registered read port with one cycle of latency.
module tag_input_pio
  import tag_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam edge_type_e ET = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] deb, deb_prev, evt, edgecap, irqmask, clr;
  logic [31:0]      rd_mux;
  logic             rd_en, wr_en;
  logic             unused_wdata;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      tag_pio_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_BIT        (IDLE_LEVEL[i])
      ) u_deb (
        .clk    (clk),
        .reset  (reset),
        .in_bit (in_port[i]),
        .deb    (deb[i])
      );
    end
  endgenerate

  assign rd_en        = chipselect & ~read_n;
  assign wr_en        = chipselect & ~write_n;
  assign clr          = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  // Upper write-data bits have no destination at narrow widths.
  assign unused_wdata = ^writedata;

  // Edge event selection on the debounced value versus its previous cycle.
  always_comb begin
    evt = '0;
    case (ET)
      EDGE_FALL: evt = deb_prev & ~deb;
      EDGE_RISE: evt = ~deb_prev & deb;
      default:   evt = deb_prev ^ deb;
    endcase
  end

  // Control registers, sticky edge bits (set beats clear) and the irq flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_prev <= IDLE_LEVEL;
      edgecap  <= '0;
      irqmask  <= '0;
      irq      <= 1'b0;
    end else begin
      deb_prev <= deb;
      edgecap  <= evt | (edgecap & ~clr);
      irq      <= |(edgecap & irqmask);
      if (wr_en && address == PIO_ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Read mux on current register state, so a simultaneous write is not visible.
  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = deb;
      PIO_ADDR_RSVD:    rd_mux = '0;
      PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:          rd_mux = '0;
    endcase
  end

  // Registered read data; holds its value when no read is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_tag_input_pio.sv
// Bench for tag_input_pio: directed scenarios plus random traffic, with a
// reference model feeding a read-data scoreboard and an irq comparison.
module tb_tag_input_pio;

  localparam int W   = 4;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         read_n = 1'b1;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] in_port = 4'hF;
  logic         irq;

  int tests = 0;
  int fails = 0;

  tag_input_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(0), .IDLE_LEVEL(4'hF)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each input bit passes two sampling stages; the filtered level adopts the
  // sampled level once it has disagreed for DEB samples in a row.
  bit [W-1:0]  m_q1, m_q2, m_deb, m_prev, m_cap, m_mask;
  int          m_streak [W];
  bit          m_irq;
  bit          rd_due;
  bit [31:0]   exp_q [$];

  always @(posedge clk or posedge reset) begin
    bit [W-1:0] ev, clr, nd;
    bit [31:0]  rv;
    int         ns [W];
    if (reset) begin
      m_q1 <= '1; m_q2 <= '1; m_deb <= '1; m_prev <= '1;
      m_cap <= '0; m_mask <= '0; m_irq <= 1'b0; rd_due <= 1'b0;
      for (int i = 0; i < W; i++) m_streak[i] <= 0;
      exp_q.delete();
    end else begin
      rd_due <= 1'b0;
      if (chipselect && !read_n) begin
        rv = 0;
        if (address == 2'd0) rv = 32'(m_deb);
        if (address == 2'd2) rv = 32'(m_mask);
        if (address == 2'd3) rv = 32'(m_cap);
        exp_q.push_back(rv);
        rd_due <= 1'b1;
      end
      ev  = m_prev & ~m_deb;
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      m_irq <= |(m_cap & m_mask);
      m_cap <= ev | (m_cap & ~clr);
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[W-1:0];
      m_prev <= m_deb;
      nd = m_deb;
      for (int i = 0; i < W; i++) begin
        ns[i] = (m_q2[i] == m_deb[i]) ? 0 : m_streak[i] + 1;
        if (ns[i] == DEB) begin
          nd[i] = m_q2[i];
          ns[i] = 0;
        end
        m_streak[i] <= ns[i];
      end
      m_deb <= nd;
      m_q2  <= m_q1;
      m_q1  <= in_port;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rd_due) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else                   check("sb_read", readdata, exp_q.pop_front());
    end
    check("sb_irq", {31'd0, irq}, {31'd0, m_irq});
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic cs, input logic rn, input logic wn,
                     input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = cs; read_n = rn; write_n = wn; address = a; writedata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(0, 1, 1, 0, 0);
  endtask

  task automatic step_in(input logic [W-1:0] v);
    bus(0, 1, 1, 0, 0);
    in_port = v;
  endtask

  task automatic rd(input logic [1:0] a);
    bus(1, 0, 1, a, 0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(1, 1, 0, a, d);
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    rd(a);
    @(posedge clk);
    #1 check(name, readdata, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    chipselect = 0; read_n = 1; write_n = 1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] cur;
    // 1: reset values
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_readdata", readdata, 0);
    check("rst_irq", {31'd0, irq}, 0);
    read_chk("rst_data", 2'd0, 32'hF);
    read_chk("rst_mask", 2'd2, 32'h0);
    read_chk("rst_cap", 2'd3, 32'h0);
    read_chk("rst_rsvd", 2'd1, 32'h0);

    // 2: falling bit 0, exact 6-cycle latency
    step_in(4'hE);
    idle(4);
    read_chk("lat_before", 2'd0, 32'hF);
    read_chk("lat_at6", 2'd0, 32'hE);
    idle(2);
    read_chk("cap_bit0", 2'd3, 32'h1);
    check("irq_masked", {31'd0, irq}, 0);

    // 3: bounce on bit 1 never settles
    cur = 4'hE;
    for (int k = 0; k < 10; k++) begin
      cur[1] = ~cur[1];
      step_in(cur);
      idle(1);
    end
    step_in(4'hE);
    idle(8);
    read_chk("bounce_data", 2'd0, 32'hE);
    read_chk("bounce_cap", 2'd3, 32'h1);

    // 4: unmask then clear
    wr(2'd2, 32'h1);
    idle(1);
    @(posedge clk); #1 check("irq_unmask", {31'd0, irq}, 1);
    wr(2'd3, 32'h1);
    idle(1);
    @(posedge clk); #1 check("irq_cleared", {31'd0, irq}, 0);
    read_chk("cap_cleared", 2'd3, 32'h0);
    read_chk("mask_rd", 2'd2, 32'h1);
    wr(2'd0, 32'h0);
    read_chk("data_ro", 2'd0, 32'hE);

    // 5: clear coincident with bit-2 falling event; set wins
    step_in(4'hA);
    idle(5);
    wr(2'd3, 32'h4);
    read_chk("set_wins", 2'd3, 32'h4);
    // read+write together returns the pre-write value
    bus(1, 0, 0, 2'd2, 32'hF);
    @(posedge clk); #1 check("rw_old", readdata, 32'h1);
    read_chk("rw_new", 2'd2, 32'hF);
    @(posedge clk); #1 check("irq_bit2", {31'd0, irq}, 1);
    wr(2'd3, 32'hF);
    idle(2);
    check("irq_clr_all", {31'd0, irq}, 0);

    // 6: reset while bit 3 mid-debounce
    step_in(4'h2);
    idle(3);
    @(negedge clk);
    reset = 1'b1;
    in_port = 4'hF;
    @(negedge clk);
    #1 check("rst2_readdata", readdata, 0);
    reset = 1'b0;
    check("rst2_irq", {31'd0, irq}, 0);
    read_chk("rst2_data", 2'd0, 32'hF);
    read_chk("rst2_mask", 2'd2, 32'h0);
    idle(10);
    read_chk("rst2_cap", 2'd3, 32'h0);

    // random traffic, model-checked
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    begin step_in(4'($urandom)); idle($urandom_range(0, 7)); end
        2, 3, 4: rd(2'($urandom));
        5:       wr(2'd2, $urandom);
        6, 7:    wr(2'($urandom), $urandom);
        8:       bus(1, 0, 0, 2'($urandom), $urandom);
        default: begin
          if (n == 200) pulse_reset();
          else idle(1);
        end
      endcase
    end
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
